// File: rtl/elev_pkg.sv
// elev_pkg: shared state, direction and floor encodings for the elevator controller
package elev_pkg;
  typedef enum logic [1:0] {IDLE, UP_RUN, DN_RUN, DOOR} state_t;
  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;
  localparam logic [3:0] FLOOR1 = 4'b0001;
  localparam logic [3:0] FLOOR2 = 4'b0010;
  localparam logic [3:0] FLOOR3 = 4'b0100;
  localparam logic [3:0] FLOOR4 = 4'b1000;
  function automatic logic [3:0] below_mask(input logic [3:0] p);
    return p - 4'd1;
  endfunction
  function automatic logic [3:0] above_mask(input logic [3:0] p);
    return ~(p | (p - 4'd1)) & 4'hF;
  endfunction
endpackage

// File: rtl/floor_travel_timer.sv
// floor_travel_timer: wrapping tick counter with clear, enable and a terminal-count pulse
module floor_travel_timer #(
  parameter int TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TICKS);
  logic [W-1:0] cnt;
  assign tc = en && (cnt == W'(TICKS - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/elev_motion_ctrl.sv
// elev_motion_ctrl: car motion sequencer (idle/run/door) for the 4-storey elevator.
// Define IDLE_RETURN_EN to send an idle car back to floor 1 after IDLE_TICKS cycles.
module elev_motion_ctrl
  import elev_pkg::*;
#(
  parameter int FLOOR_TICKS = 8,
  parameter int IDLE_TICKS = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] allReq,
  input  logic       up_need,
  input  logic       down_need,
  input  logic       endOpen,
  output logic [3:0] position,
  output logic [1:0] ud_mode,
  output logic       opendoor,
  output logic       moving,
  output logic       arrive
);
  state_t state;
  logic run, run_tc, idle_tc, homing;
  logic [3:0] up_pos, dn_pos;
  logic up_req, dn_req, here, up_stop, dn_hit, dn_stop, dir_up, go_up, go_dn;
  assign run = (state == UP_RUN) || (state == DN_RUN);
  assign up_req = |(allReq & above_mask(position));
  assign dn_req = |(allReq & below_mask(position));
  assign here = |(allReq & position);
  assign up_pos = position << 1;
  assign dn_pos = position >> 1;
  assign up_stop = |(allReq & up_pos) || (up_pos == FLOOR4);
  assign dn_hit = |(allReq & dn_pos);
  assign dn_stop = dn_hit || (dn_pos == FLOOR1);
  assign dir_up = ud_mode == UD_UP;
  assign go_up = dir_up ? up_req : (!dn_req && up_req);
  assign go_dn = dir_up ? (!up_req && dn_req) : dn_req;
  floor_travel_timer #(.TICKS(FLOOR_TICKS)) u_travel (
    .clk(clk), .rst(rst), .clr(!run), .en(run), .tc(run_tc)
  );
`ifdef IDLE_RETURN_EN
  logic idle_en;
  assign idle_en = (state == IDLE) && (allReq == 4'd0) && (position != FLOOR1);
  floor_travel_timer #(.TICKS(IDLE_TICKS)) u_idle (
    .clk(clk), .rst(rst), .clr(!idle_en), .en(idle_en), .tc(idle_tc)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) homing <= 1'b0;
    else if (state == IDLE && idle_tc && !here) homing <= 1'b1;
    else if (state == DN_RUN && run_tc && dn_stop) homing <= 1'b0;
`else
  assign idle_tc = 1'b0;
  assign homing = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      position <= FLOOR1;
      ud_mode <= UD_STOP;
      opendoor <= 1'b0;
      moving <= 1'b0;
      arrive <= 1'b0;
    end else begin
      arrive <= 1'b0;
      case (state)
        IDLE:
          if (here) begin
            state <= DOOR;
            ud_mode <= (position == FLOOR4) ? UD_DOWN : UD_UP;
            opendoor <= 1'b1;
            arrive <= 1'b1;
          end else if (up_need && up_req) begin
            state <= UP_RUN;
            ud_mode <= UD_UP;
            moving <= 1'b1;
          end else if ((down_need && dn_req) || idle_tc) begin
            state <= DN_RUN;
            ud_mode <= UD_DOWN;
            moving <= 1'b1;
          end else ud_mode <= UD_STOP;
        UP_RUN:
          if (run_tc) begin
            position <= up_pos;
            if (up_stop) begin
              state <= DOOR;
              opendoor <= 1'b1;
              arrive <= 1'b1;
              moving <= 1'b0;
            end
          end
        DN_RUN:
          if (run_tc) begin
            position <= dn_pos;
            if (dn_stop) begin
              moving <= 1'b0;
              // a homing run that reaches floor 1 with nothing requested parks shut
              if (homing && !dn_hit) begin
                state <= IDLE;
                ud_mode <= UD_STOP;
              end else begin
                state <= DOOR;
                opendoor <= 1'b1;
                arrive <= 1'b1;
              end
            end
          end
        DOOR:
          if (endOpen) begin
            opendoor <= 1'b0;
            if (go_up) begin
              state <= UP_RUN;
              ud_mode <= UD_UP;
              moving <= 1'b1;
            end else if (go_dn) begin
              state <= DN_RUN;
              ud_mode <= UD_DOWN;
              moving <= 1'b1;
            end else begin
              state <= IDLE;
              ud_mode <= UD_STOP;
            end
          end
        default: state <= IDLE;
      endcase
    end
  assert property (@(posedge clk) disable iff (rst)
    !(state == UP_RUN && position == FLOOR4) && !(state == DN_RUN && position == FLOOR1));
endmodule

// File: tb/tb_elev_motion_ctrl.sv
// tb_elev_motion_ctrl: directed scenarios for the elevator motion sequencer
module tb_elev_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] allReq = 4'd0;
  logic up_need = 1'b0, down_need = 1'b0, endOpen = 1'b0;
  logic [3:0] position;
  logic [1:0] ud_mode;
  logic opendoor, moving, arrive;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  elev_motion_ctrl dut (
    .clk(clk), .rst(rst), .allReq(allReq), .up_need(up_need), .down_need(down_need),
    .endOpen(endOpen), .position(position), .ud_mode(ud_mode), .opendoor(opendoor),
    .moving(moving), .arrive(arrive)
  );
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string name, input logic [3:0] pos, input logic [1:0] ud,
                     input logic od, input logic mv, input logic ar);
    n_checks++;
    if ({position, ud_mode, opendoor, moving, arrive} !== {pos, ud, od, mv, ar}) begin
      n_fail++;
      $display("FAIL %s got pos=%b ud=%b od=%b mv=%b ar=%b exp pos=%b ud=%b od=%b mv=%b ar=%b",
               name, position, ud_mode, opendoor, moving, arrive, pos, ud, od, mv, ar);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    allReq = 4'd0; up_need = 1'b0; down_need = 1'b0; endOpen = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    chk("reset", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
    endOpen = 1'b1;
    tick(2);
    chk("endopen_ignored", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
    endOpen = 1'b0;
  endtask
  task automatic test_up_run();
    do_reset();
    allReq = 4'b1000; up_need = 1'b1;
    tick(1);
    chk("up_entry", 4'b0001, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(7);
    chk("up_c7", 4'b0001, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("up_c8", 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(8);
    chk("up_c16", 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(7);
    chk("up_c23", 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("up_c24_arrive", 4'b1000, 2'b01, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk("up_door_hold", 4'b1000, 2'b01, 1'b1, 1'b0, 1'b0);
    allReq = 4'd0; up_need = 1'b0; endOpen = 1'b1;
    tick(1);
    chk("up_to_idle", 4'b1000, 2'b00, 1'b0, 1'b0, 1'b0);
    endOpen = 1'b0;
  endtask
  task automatic test_forced_stop_top();
    do_reset();
    allReq = 4'b0100; up_need = 1'b1;
    tick(17);
    chk("fs_at_f3", 4'b0100, 2'b01, 1'b1, 1'b0, 1'b1);
    allReq = 4'b1000; endOpen = 1'b1;
    tick(1);
    chk("fs_leave_f3", 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0);
    endOpen = 1'b0;
    tick(3);
    allReq = 4'b0001; up_need = 1'b0; down_need = 1'b1;
    tick(5);
    chk("fs_forced_f4", 4'b1000, 2'b01, 1'b1, 1'b0, 1'b1);
    endOpen = 1'b1;
    tick(1);
    chk("fs_reverse", 4'b1000, 2'b10, 1'b0, 1'b1, 1'b0);
    endOpen = 1'b0;
    tick(8);
    chk("fs_dn_f3", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    tick(16);
    chk("fs_dn_f1", 4'b0001, 2'b10, 1'b1, 1'b0, 1'b1);
  endtask
  task automatic test_door_here();
    do_reset();
    allReq = 4'b0001;
    tick(1);
    chk("here_door", 4'b0001, 2'b01, 1'b1, 1'b0, 1'b1);
    tick(3);
    chk("here_hold", 4'b0001, 2'b01, 1'b1, 1'b0, 1'b0);
    allReq = 4'd0; endOpen = 1'b1;
    tick(1);
    chk("here_idle", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
    endOpen = 1'b0;
  endtask
  task automatic test_intermediate_stop();
    do_reset();
    allReq = 4'b1010; up_need = 1'b1;
    tick(9);
    chk("mid_f2_door", 4'b0010, 2'b01, 1'b1, 1'b0, 1'b1);
    allReq = 4'b1001; down_need = 1'b1; endOpen = 1'b1;
    tick(1);
    chk("mid_keep_up", 4'b0010, 2'b01, 1'b0, 1'b1, 1'b0);
    endOpen = 1'b0;
    tick(8);
    chk("mid_pass_f3", 4'b0100, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(8);
    chk("mid_f4_door", 4'b1000, 2'b01, 1'b1, 1'b0, 1'b1);
  endtask
  task automatic test_reset_mid_run();
    do_reset();
    allReq = 4'b0100; up_need = 1'b1;
    tick(17);
    allReq = 4'b0001; up_need = 1'b0; down_need = 1'b1; endOpen = 1'b1;
    tick(1);
    chk("rmr_dn_entry", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    endOpen = 1'b0;
    tick(5);
    #2 rst = 1'b1;
    #1 chk("rmr_async", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
    allReq = 4'd0; down_need = 1'b0;
    tick(1);
    rst = 1'b0;
    allReq = 4'b0010; up_need = 1'b1;
    tick(8);
    chk("rmr_c7", 4'b0001, 2'b01, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("rmr_c8", 4'b0010, 2'b01, 1'b1, 1'b0, 1'b1);
  endtask
`ifdef IDLE_RETURN_EN
  task automatic test_idle_return();
    do_reset();
    allReq = 4'b0100; up_need = 1'b1;
    tick(17);
    allReq = 4'd0; up_need = 1'b0; endOpen = 1'b1;
    tick(1);
    endOpen = 1'b0;
    chk("home_parked", 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(39);
    chk("home_c39", 4'b0100, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("home_c40", 4'b0100, 2'b10, 1'b0, 1'b1, 1'b0);
    tick(15);
    chk("home_c15", 4'b0010, 2'b10, 1'b0, 1'b1, 1'b0);
    tick(1);
    chk("home_f1", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("home_stays", 4'b0001, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask
`endif
  initial begin
    test_reset();
    test_up_run();
    test_forced_stop_top();
    test_door_here();
    test_intermediate_stop();
    test_reset_mid_run();
`ifdef IDLE_RETURN_EN
    test_idle_return();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/elev_motion_ctrl.md
# elev_motion_ctrl

Car motion sequencer for the 4-storey elevator controller. It consumes the registered request set and up/down needs from the request-processing stage, plus the door timer's end-of-open flag. It drives car position, run mode (fed back to the request stage for request clearing) and the door-open command that starts the door timer. It runs on the 4 Hz system clock and models floor-to-floor travel time with an internal tick counter.

## Interface

- FLOOR_TICKS, 8, clock cycles to travel one floor (8 = 2 s at 4 Hz); legal range 2..127
- IDLE_TICKS, 40, idle cycles before return-home; used only with IDLE_RETURN_EN
- clk  in  1  4 Hz system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- allReq  in  4  one-hot-per-floor set of valid requests (bit0 = floor 1)
- up_need  in  1  request-stage flag: service wanted above car
- down_need  in  1  request-stage flag: service wanted below car
- endOpen  in  1  door timer finished; sampled only in DOOR
- position  out  4  one-hot car floor
- ud_mode  out  2  00 stop, 01 up, 10 down; 11 never driven
- opendoor  out  1  level; high for the whole DOOR state (door timer StOpen)
- moving  out  1  high in UP_RUN / DN_RUN
- arrive  out  1  one-cycle pulse on the cycle DOOR is entered

## Operation

- Masks from one-hot p = position: below = p − 1; above = ~(p | (p − 1)) & 4'hF; here = allReq & p.
- States: IDLE, UP_RUN, DN_RUN, DOOR.
- IDLE, priority order:
  - here ≠ 0 → DOOR; ud_mode = 01, or 10 if p = floor 4.
  - else up_need & (allReq & above) ≠ 0 → UP_RUN.
  - else down_need & (allReq & below) ≠ 0 → DN_RUN.
  - else stay; ud_mode = 00.
- UP_RUN: ud_mode = 01; travel counter counts 0..FLOOR_TICKS−1.
  - At terminal count, position shifts left one place.
  - If allReq & new position ≠ 0, or new position = floor 4 → DOOR.
  - Otherwise the counter restarts.
- DN_RUN: mirror of UP_RUN; shift right; forced stop at floor 1.
- DOOR: opendoor = 1; ud_mode holds arrival direction so the request stage clears requests at this floor. On endOpen = 1, decide with the direction kept first:
  - up: allReq & above ≠ 0 → UP_RUN; else allReq & below ≠ 0 → DN_RUN; else IDLE.
  - down: the same with the roles of above and below swapped.
- Position never shifts outside 4 bits. A shift from floor 4 up, or from floor 1 down, is unreachable. An assertion covers this in simulation.
- Requests that appear or vanish mid-travel are evaluated only at floor boundaries (terminal count).

## Timing

- Reset values: state IDLE, position 4'b0001, ud_mode 00, opendoor 0, moving 0, arrive 0, all counters 0. Reset mid-run or mid-door returns the car to floor 1 immediately.
- IDLE → run: one cycle after the need and request are sampled. moving rises on that edge.
- One floor of travel takes exactly FLOOR_TICKS cycles from run entry to the position update.
- Arrival: position update, DOOR entry, opendoor rising and the arrive pulse all occur on the same edge.
- DOOR → next state: on the edge after endOpen is sampled high; opendoor falls on that edge.
- endOpen high while not in DOOR is ignored.
- All outputs are registered; no combinational input-to-output paths.

## Configuration

- IDLE_RETURN_EN defined: in IDLE with allReq = 0 and position ≠ floor 1, an idle counter runs.
  - At IDLE_TICKS it enters DN_RUN with a homing flag set.
  - Homing arrival at floor 1 goes to IDLE without opening the door.
  - A request matched during homing stops normally (DOOR) and clears the flag.
  - Any nonzero allReq resets the idle counter.
- IDLE_RETURN_EN undefined: there is no idle counter and no homing; the car parks where it last stopped.

## Structure

- Package elev_pkg holds:
  - the state enum;
  - UD_STOP/UD_UP/UD_DOWN 2-bit constants;
  - FLOOR1..FLOOR4 one-hot constants, shared with the request stage and the door timer.
- Sub-module floor_travel_timer: clear, enable and terminal-count pulse, width sized from FLOOR_TICKS. The idle counter reuses it with IDLE_TICKS.

## Test plan

- Reset, then allReq = 4'b1000 with up_need = 1: UP_RUN. position reaches 0010, 0100, then 1000 at cycles 8, 16 and 24. arrive pulses at 24, opendoor = 1, ud_mode = 01.
- Car at floor 3 going up, allReq = 4'b0001 arrives during travel: at floor 4 the forced stop opens the door. After endOpen, DN_RUN runs to floor 1.
- allReq = 4'b0001 at floor 1 in IDLE: DOOR next cycle with ud_mode = 01 and moving never rises.
- allReq = 4'b1010 from floor 1: stops at floor 2 with the door open. After endOpen, continues up to floor 4; no reversal.
- Assert rst during DN_RUN at cycle 5 of travel: all outputs return to reset values asynchronously, and the run restarts cleanly after release.
- IDLE_RETURN_EN: parked at floor 3 with no requests for 40 cycles → DN_RUN. Reaches floor 1 at +16 cycles with opendoor staying 0.
